// File: rtl/pipeline_lut_multiplier.sv
// Signed 8x8 -> 16 multiplier built from the quarter-square identity:
//   A*B = floor((A+B)^2/4) - floor((A-B)^2/4)
// Four register stages (sum/diff, magnitude, ROM lookup, subtract) give a
// latency of three edges after the sampling edge and one result per clock.
// Squares come from a constant ROM, so no hardware multiplier is inferred.
module pipeline_lut_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] product
);

  // Quarter-square ROM: lut[n] = floor(n*n/4). Every entry is a constant
  // because n is a genvar; only 0..256 is reachable from the magnitudes.
  logic [15:0] lut [512];

  for (genvar n = 0; n < 512; n++) begin : g_lut
    assign lut[n] = 16'((n * n) / 4);
  end

  // Stage 1: sign-extended sum and difference (cannot overflow 9 bits).
  logic signed [8:0] s_d, s_q;
  logic signed [8:0] d_d, d_q;
  // Stage 2: magnitudes, 9-bit unsigned so |-256| = 256 without wrap.
  logic [8:0] s_abs_d, s_abs_q;
  logic [8:0] d_abs_d, d_abs_q;
  // Stage 3: ROM outputs.
  logic [15:0] q1_d, q1_q;
  logic [15:0] q2_d, q2_q;
  // Stage 4: product register.
  logic [15:0] product_d, product_q;

  // Next-state logic for every pipeline stage.
  // NOTE: each always_comb output is assigned a default on entry, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    s_d       = $signed({A[7], A}) + $signed({B[7], B});
    d_d       = $signed({A[7], A}) - $signed({B[7], B});
    s_abs_d   = s_q[8] ? 9'(-s_q) : 9'(s_q);
    d_abs_d   = d_q[8] ? 9'(-d_q) : 9'(d_q);
    q1_d      = lut[s_abs_q];
    q2_d      = lut[d_abs_q];
    product_d = q1_q - q2_q;
  end

  // Pipeline registers; asynchronous reset flushes every stage at once.
  // NOTE: sequential state uses non-blocking assignments so all stages
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      d_q       <= '0;
      s_abs_q   <= '0;
      d_abs_q   <= '0;
      q1_q      <= '0;
      q2_q      <= '0;
      product_q <= '0;
    end else begin
      s_q       <= s_d;
      d_q       <= d_d;
      s_abs_q   <= s_abs_d;
      d_abs_q   <= d_abs_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_pipeline_lut_multiplier.sv
// Bench for pipeline_lut_multiplier: a delay-line model of true signed
// products checked every cycle, plus directed vectors with literal results.
module tb_pipeline_lut_multiplier;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model: exact signed products of the operands sampled on each of the
  // last four edges; index 3 is what must be on product now.
  int hist [4];

  pipeline_lut_multiplier dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    A = a;
    B = b;
  endtask

  // Apply one pair, hold it, and check the literal result after latency.
  task automatic check_pair(input string name, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] exp);
    apply(a, b);
    repeat (4) @(posedge clk);
    #1 check(name, product, exp);
  endtask

  // Reference model: record each sampled product, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= 0;
    end else begin
      hist[0] <= int'($signed(A)) * int'($signed(B));
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) check("pipe_model", product, 16'(hist[3]));
  end

  initial begin
    rst_n = 1'b1;
    A     = '0;
    B     = '0;
    #1 rst_n = 1'b0;
    #1 check_en = 1'b1;
    check("reset_zero", product, 16'h0000);

    // Release at t=250 with zero operands; product must stay zero.
    #248 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("post_reset_zero", product, 16'h0000);

    // Back-to-back directed sequence, last pair held.
    apply(8'd15, 8'd34);
    apply(8'hEC, 8'd59);
    apply(8'h81, 8'd127);
    @(posedge clk);                 // edge sampling the third pair
    @(posedge clk); #1 check("seq_15x34",    product, 16'h01FE);
    @(posedge clk); #1 check("seq_m20x59",   product, 16'hFB64);
    @(posedge clk); #1 check("seq_m127x127", product, 16'hC0FF);
    repeat (3) @(posedge clk);
    #1 check("seq_hold", product, 16'hC0FF);

    // Boundary operands.
    check_pair("m128xm128", 8'h80, 8'h80, 16'h4000);
    check_pair("m128x127",  8'h80, 8'h7F, 16'hC080);
    check_pair("127xm128",  8'h7F, 8'h80, 16'hC080);
    check_pair("m1xm1",     8'hFF, 8'hFF, 16'h0001);
    check_pair("0xm128",    8'h00, 8'h80, 16'h0000);
    check_pair("127x127",   8'h7F, 8'h7F, 16'h3F01);

    // Alternating signs every cycle; both give -10000.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) apply(8'd100, 8'h9C);
      else            apply(8'h9C, 8'd100);
    end
    repeat (4) @(posedge clk);
    #1 check("alt_100", product, 16'hD8F0);

    // Fill the pipeline with distinct values, then reset between edges.
    apply(8'd50, 8'd3);
    apply(8'd7, 8'hF7);
    apply(8'h7F, 8'h7F);
    apply(8'h80, 8'h80);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_flush", product, 16'h0000);
    repeat (2) @(posedge clk);
    #1 check("flush_hold", product, 16'h0000);
    @(negedge clk);
    A = 8'd3;
    B = 8'd4;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("refill_empty", product, 16'h0000);
    @(posedge clk);
    #1 check("refill_3x4", product, 16'h000C);

    // Exhaustive sweep, one pair per clock, checked by the model.
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      A = i[15:8];
      B = i[7:0];
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
